// File: rtl/manual_auto_pkg.sv
// Shared types and defaults for the manual/auto mode switch conditioner.
// The FSM state type and the default qualification constants live here.
package manual_auto_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } ma_state_e;

    localparam int MA_DEBOUNCE_CYCLES_DEF = 500000;
    localparam int MA_SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/manual_auto_debounce_sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous pin into clk.
// Shared by the pin-input blocks; holds no logic beyond the flop chain.
module sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/manual_auto_debounce.sv
// manual_auto_debounce: synchronise, debounce and edge-detect the manual/auto mode pin.
// Define MANUAL_AUTO_TOGGLE_EN to turn mode into a push-button toggle instead of following level.
module manual_auto_debounce
    import manual_auto_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = MA_DEBOUNCE_CYCLES_DEF,
    parameter int   SYNC_STAGES     = MA_SYNC_STAGES_DEF,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic mode,
    output logic busy
);

    // state  | meaning
    // STABLE | level matches sync, waiting for the first differing sample
    // CHECK  | sync differs from level, counting consecutive differing samples

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    ma_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             sync;
    logic             differ;
    logic             accept;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sw_raw),
        .q       (sync)
    );

    assign differ = (sync != level);

    // A single-sample qualification accepts straight from STABLE.
    always_comb begin
        accept = 1'b0;
        case (state)
            STABLE:  accept = differ && (DEBOUNCE_CYCLES == 1);
            CHECK:   accept = differ && (cnt == CNT_LAST);
            default: accept = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STABLE;
            cnt        <= '0;
            level      <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
`ifdef MANUAL_AUTO_TOGGLE_EN
            mode       <= 1'b0;
`endif
        end else begin
            rise_pulse <= accept && sync;
            fall_pulse <= accept && !sync;
            if (accept) begin
                level <= sync;
            end
`ifdef MANUAL_AUTO_TOGGLE_EN
            if (accept && sync) begin
                mode <= ~mode;
            end
`endif
            case (state)
                STABLE: begin
                    if (differ && !accept) begin
                        state <= CHECK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!differ || accept) begin
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef MANUAL_AUTO_TOGGLE_EN
    assign mode = level;
`endif

endmodule

// File: tb/tb_manual_auto_debounce.sv
// Bench for manual_auto_debounce: a 4-sample instance and a 1-sample instance share one stimulus.
// Outputs are checked every cycle against a sample-history model, plus hand-computed edge checks.
module tb_manual_auto_debounce;

    logic clk = 1'b0;
    logic reset_n;
    logic sw_raw;
    logic level, rise_pulse, fall_pulse, mode, busy;
    logic level1, rise1, fall1, mode1, busy1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit busy1_seen = 1'b0;

    always #5 clk = ~clk;

    manual_auto_debounce #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .level      (level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .mode       (mode),
        .busy       (busy)
    );

    manual_auto_debounce #(
        .DEBOUNCE_CYCLES (1),
        .SYNC_STAGES     (2),
        .RESET_LEVEL     (1'b0)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw),
        .level      (level1),
        .rise_pulse (rise1),
        .fall_pulse (fall1),
        .mode       (mode1),
        .busy       (busy1)
    );

    task automatic cmp(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the pin reaches the FSM two edges late; a level is accepted once the
    // most recent D samples all disagree with it.
    int   dc [2] = '{4, 1};
    logic dq [$];
    logic hist [$];
    logic m_level [2];
    logic m_rise  [2];
    logic m_fall  [2];
    logic m_busy  [2];
    logic m_mode  [2];
    logic samp;
    logic acc;
    int   run;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq = {};
            dq.push_back(1'b0);
            dq.push_back(1'b0);
            hist = {};
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 1'b0;
                m_rise[i]  = 1'b0;
                m_fall[i]  = 1'b0;
                m_busy[i]  = 1'b0;
                m_mode[i]  = 1'b0;
            end
        end else begin
            samp = dq.pop_back();
            dq.push_front(sw_raw);
            hist.push_back(samp);
            if (hist.size() > 16) void'(hist.pop_front());
            for (int i = 0; i < 2; i++) begin
                run = 0;
                for (int j = hist.size() - 1; j >= 0; j--) begin
                    if (hist[j] == m_level[i] || run >= dc[i]) break;
                    run++;
                end
                acc       = (run >= dc[i]);
                m_rise[i] = acc && !m_level[i];
                m_fall[i] = acc && m_level[i];
                m_busy[i] = !acc && (run > 0);
                if (acc) m_level[i] = ~m_level[i];
`ifdef MANUAL_AUTO_TOGGLE_EN
                if (m_rise[i]) m_mode[i] = ~m_mode[i];
`else
                m_mode[i] = m_level[i];
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("d4.level", level,      m_level[0]);
            cmp("d4.rise",  rise_pulse, m_rise[0]);
            cmp("d4.fall",  fall_pulse, m_fall[0]);
            cmp("d4.busy",  busy,       m_busy[0]);
            cmp("d4.mode",  mode,       m_mode[0]);
            cmp("d4.pulse_excl", rise_pulse & fall_pulse, 1'b0);
            cmp("d1.level", level1, m_level[1]);
            cmp("d1.rise",  rise1,  m_rise[1]);
            cmp("d1.fall",  fall1,  m_fall[1]);
            cmp("d1.busy",  busy1,  m_busy[1]);
            cmp("d1.mode",  mode1,  m_mode[1]);
            if (busy1) busy1_seen = 1'b1;
        end
    end

    initial begin
        reset_n = 1'b0;
        sw_raw  = 1'b1;
        // Reset held with the pin high: nothing may move.
        repeat (3) begin
            @(negedge clk);
            chk_en = 1'b1;
            #1;
            cmp("rst.level", level, 1'b0);
            cmp("rst.rise",  rise_pulse, 1'b0);
            cmp("rst.busy",  busy, 1'b0);
        end
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("pwr.busy_e2", busy, 1'b0);
        cmp("pwr.d1_level_e2", level1, 1'b0);
        @(posedge clk); #1;
        cmp("pwr.busy_e3", busy, 1'b1);
        cmp("pwr.d1_level_e3", level1, 1'b1);
        cmp("pwr.d1_rise_e3", rise1, 1'b1);
        repeat (2) @(posedge clk); #1;
        cmp("pwr.level_e5", level, 1'b0);
        @(posedge clk); #1;
        cmp("pwr.level_e6", level, 1'b1);
        cmp("pwr.rise_e6", rise_pulse, 1'b1);
        @(posedge clk); #1;
        cmp("pwr.rise_e7", rise_pulse, 1'b0);

        // Clean 1->0.
        @(negedge clk); #1;
        sw_raw = 1'b0;
        repeat (5) @(posedge clk); #1;
        cmp("fall.level_e5", level, 1'b1);
        cmp("fall.pulse_e5", fall_pulse, 1'b0);
        @(posedge clk); #1;
        cmp("fall.level_e6", level, 1'b0);
        cmp("fall.fall_e6", fall_pulse, 1'b1);
        cmp("fall.rise_e6", rise_pulse, 1'b0);

        // Bounce: three high samples never qualify.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            sw_raw = 1'b1;
            repeat (3) @(negedge clk);
            cmp("bounce.busy_hi", busy, 1'b1);
            #1;
            sw_raw = 1'b0;
            repeat (3) @(negedge clk);
            cmp("bounce.busy_lo", busy, 1'b0);
            cmp("bounce.level", level, 1'b0);
        end

        // Reset in the middle of qualification.
        repeat (4) @(negedge clk);
        #1;
        sw_raw = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        cmp("midrst.busy", busy, 1'b0);
        cmp("midrst.level", level, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        cmp("midrst.level_e5", level, 1'b0);
        @(posedge clk); #1;
        cmp("midrst.level_e6", level, 1'b1);

        // Three press/release cycles from a fresh reset.
        @(negedge clk); #1;
        sw_raw  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sw_raw = 1'b1;
            repeat (8) @(negedge clk);
`ifdef MANUAL_AUTO_TOGGLE_EN
            cmp("press.mode", mode, (k % 2 == 0) ? 1'b1 : 1'b0);
`else
            cmp("press.mode", mode, 1'b1);
`endif
            #1;
            sw_raw = 1'b0;
            repeat (8) @(negedge clk);
`ifdef MANUAL_AUTO_TOGGLE_EN
            cmp("release.mode", mode, (k % 2 == 0) ? 1'b1 : 1'b0);
`else
            cmp("release.mode", mode, 1'b0);
`endif
            #1;
        end

        // Random holds and occasional resets against the model.
        for (int t = 0; t < 400; t++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 99) < 3) begin
                reset_n = 1'b0;
                @(negedge clk); #1;
                reset_n = 1'b1;
            end
            sw_raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 9)) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        cmp("d1.busy_never", busy1_seen, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
